ram_arbiter: RTL



---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous RAM between a CPU and a video fetcher.
// Optional contention counter enabled by defining ARB_CONTENTION_CNT_EN.
module ram_arbiter #(
  parameter logic [15:0] RAM_TOP = 16'hB000
) (
  input  logic        phi,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_dbo,
  output logic [7:0]  cpu_dbi,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [15:0] vid_adr,
  output logic [7:0]  vid_dbi,
  output logic        vid_ack,
  output logic [15:0] ram_adr,
  output logic        ram_we,
  output logic [7:0]  ram_dbi,
  input  logic [7:0]  ram_dbo
`ifdef ARB_CONTENTION_CNT_EN
  ,
  output logic [15:0] contention_cnt
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StCap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q;
  logic        gnt_vid_q;
  logic        last_vid_q;  // set when video won the last grant
  logic        cpu_oor_q;   // granted CPU access lies outside RAM
  logic [7:0]  cpu_dbi_q, vid_dbi_q, ram_dbi_q;
  logic        cpu_ack_q, vid_ack_q, ram_we_q;
  logic [15:0] ram_adr_q;
  logic        pick_vid;
  logic        cpu_in_range;

  always_comb begin
    cpu_in_range = cpu_adr < RAM_TOP;
    // Video wins when alone, or on contention when the CPU won last time.
    pick_vid     = vid_req & (~cpu_req | ~last_vid_q);
  end

  always_ff @(posedge phi) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_vid_q  <= 1'b0;
      last_vid_q <= 1'b1;
      cpu_oor_q  <= 1'b0;
      cpu_dbi_q  <= 8'h00;
      vid_dbi_q  <= 8'h00;
      ram_dbi_q  <= 8'h00;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_adr_q  <= 16'h0000;
    end else begin
      cpu_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      ram_we_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req || vid_req) begin
            gnt_vid_q  <= pick_vid;
            last_vid_q <= pick_vid;
            state_q    <= StAcc;
            if (pick_vid) begin
              ram_adr_q <= vid_adr;
            end else begin
              ram_adr_q <= cpu_adr;
              ram_dbi_q <= cpu_dbo;
              ram_we_q  <= cpu_we & cpu_in_range;
              cpu_oor_q <= ~cpu_in_range;
            end
          end
        end
        StAcc: state_q <= StCap;
        StCap: begin
          if (gnt_vid_q) begin
            vid_dbi_q <= ram_dbo;
            vid_ack_q <= 1'b1;
          end else begin
            cpu_dbi_q <= cpu_oor_q ? 8'h00 : ram_dbo;
            cpu_ack_q <= 1'b1;
          end
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_CONTENTION_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge phi) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else if (state_q == StIdle && cpu_req && vid_req && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign contention_cnt = cnt_q;
`endif

  assign cpu_dbi = cpu_dbi_q;
  assign vid_dbi = vid_dbi_q;
  assign cpu_ack = cpu_ack_q;
  assign vid_ack = vid_ack_q;
  assign ram_adr = ram_adr_q;
  assign ram_we  = ram_we_q;
  assign ram_dbi = ram_dbi_q;

endmodule
